// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants, state encoding and helpers for the
// iterative signed multiply/divide sequencer (muldiv_seq).
package muldiv_pkg;

   localparam int XLEN  = 32;
   localparam int STEPS = 32;

   // Most negative 32-bit value; its magnitude is not representable as a
   // positive signed number but is exact as an unsigned one.
   localparam logic [31:0] OVF_VALUE = 32'h8000_0000;

   // Sequencer states
   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_MULT  = 3'd1;
   localparam state_t ST_DIV   = 3'd2;
   localparam state_t ST_DSIGN = 3'd3;
   localparam state_t ST_DONE  = 3'd4;

   // Unsigned magnitude of a two's-complement operand
   function automatic logic [31:0] magnitude(input logic [31:0] v);
      if (v == OVF_VALUE)
         return OVF_VALUE;
      return v[31] ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/muldiv_seq_booth_step.sv
// booth_step: one combinational radix-2 Booth add/shift on the
// {A, Q, Q-1} accumulator. The add is done one bit wider than A so the
// arithmetic shift brings in the true sign even when A +/- M overflows
// 32 bits (e.g. multiplicand 0x80000000).
module booth_step
   import muldiv_pkg::*;
(
   input  logic [2*XLEN:0]   acc_in,
   input  logic [XLEN-1:0]   mcand,
   output logic [2*XLEN:0]   acc_out
);

   logic [XLEN:0] a_ext;
   logic [XLEN:0] m_ext;
   logic [XLEN:0] sum;

   // Add/subtract per {Q0, Q-1}, then shift the whole accumulator right
   always_comb begin
      a_ext = {acc_in[2*XLEN], acc_in[2*XLEN:XLEN+1]};
      m_ext = {mcand[XLEN-1], mcand};
      case (acc_in[1:0])
         2'b01:   sum = a_ext + m_ext;
         2'b10:   sum = a_ext - m_ext;
         default: sum = a_ext;
      endcase
      acc_out = {sum, acc_in[XLEN:1]};
   end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative signed MULT (32-step Booth) / DIV (32-step
// restoring) sequencer feeding HI/LO.
// Optional macro MULDIV_DIVZERO_EXC_EN: adds the div_zero pulse and
// suppresses the HI/LO write on a zero divisor.
module muldiv_seq
   import muldiv_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        start_mult,
   input  logic        start_div,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic        busy,
   output logic        done,
   output logic        write_hi,
   output logic        write_lo,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out
`ifdef MULDIV_DIVZERO_EXC_EN
   ,
   output logic        div_zero
`endif
);

   state_t      state_reg;
   state_t      state_next;
   logic [4:0]  count_reg;

   logic [64:0] acc_reg;
   logic [31:0] mcand_reg;
   logic [64:0] step_acc;

   logic [31:0] rem_reg;
   logic [31:0] quo_reg;
   logic [31:0] dvs_reg;
   logic        q_neg_reg;
   logic        r_neg_reg;

   logic [31:0] hi_reg;
   logic [31:0] lo_reg;
   logic        done_reg;
   logic        wr_reg;
`ifdef MULDIV_DIVZERO_EXC_EN
   logic        divz_reg;
`endif

   logic        accept_mult;
   logic        accept_div;
   logic        div_by_zero;
   logic [32:0] div_shift;
   logic        div_fits;

   assign accept_mult = (state_reg == ST_IDLE) && start_mult;
   assign accept_div  = (state_reg == ST_IDLE) && !start_mult && start_div;
   assign div_by_zero = accept_div && (op_b == 32'd0);

   // One restoring-divide step: shift in next dividend bit, trial subtract
   assign div_shift = {rem_reg, quo_reg[31]};
   assign div_fits  = (div_shift >= {1'b0, dvs_reg});

   booth_step u_booth (
      .acc_in  (acc_reg),
      .mcand   (mcand_reg),
      .acc_out (step_acc)
   );

   // Next-state selection; starts are only looked at in IDLE
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (accept_mult)
               state_next = ST_MULT;
            else if (div_by_zero)
               state_next = ST_DONE;
            else if (accept_div)
               state_next = ST_DIV;
         end
         ST_MULT:  if (count_reg == 5'd0) state_next = ST_DONE;
         ST_DIV:   if (count_reg == 5'd0) state_next = ST_DSIGN;
         ST_DSIGN: state_next = ST_DONE;
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // State register and step counter
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         count_reg <= 5'd0;
      end else begin
         state_reg <= state_next;
         if (accept_mult || (accept_div && !div_by_zero))
            count_reg <= 5'(STEPS - 1);
         else if ((state_reg == ST_MULT) || (state_reg == ST_DIV))
            count_reg <= count_reg - 5'd1;
      end
   end

   // Iteration datapath: Booth accumulator and divide remainder/quotient
   always_ff @(posedge clock) begin
      if (reset) begin
         acc_reg   <= '0;
         mcand_reg <= '0;
         rem_reg   <= '0;
         quo_reg   <= '0;
         dvs_reg   <= '0;
         q_neg_reg <= 1'b0;
         r_neg_reg <= 1'b0;
      end else begin
         if (accept_mult) begin
            acc_reg   <= {32'd0, op_b, 1'b0};
            mcand_reg <= op_a;
         end else if (accept_div && !div_by_zero) begin
            rem_reg   <= 32'd0;
            quo_reg   <= magnitude(op_a);
            dvs_reg   <= magnitude(op_b);
            q_neg_reg <= op_a[31] ^ op_b[31];
            r_neg_reg <= op_a[31];
         end else if (state_reg == ST_MULT) begin
            acc_reg <= step_acc;
         end else if (state_reg == ST_DIV) begin
            rem_reg <= div_fits ? (div_shift[31:0] - dvs_reg) : div_shift[31:0];
            quo_reg <= {quo_reg[30:0], div_fits};
         end
      end
   end

   // Result registers and strobes, loaded on the edge that enters DONE
   always_ff @(posedge clock) begin
      if (reset) begin
         hi_reg   <= 32'd0;
         lo_reg   <= 32'd0;
         done_reg <= 1'b0;
         wr_reg   <= 1'b0;
`ifdef MULDIV_DIVZERO_EXC_EN
         divz_reg <= 1'b0;
`endif
      end else begin
         done_reg <= 1'b0;
         wr_reg   <= 1'b0;
`ifdef MULDIV_DIVZERO_EXC_EN
         divz_reg <= 1'b0;
`endif
         case (state_reg)
            ST_IDLE: begin
               if (div_by_zero) begin
                  done_reg <= 1'b1;
`ifdef MULDIV_DIVZERO_EXC_EN
                  divz_reg <= 1'b1;
`else
                  wr_reg   <= 1'b1;
                  hi_reg   <= op_a;
                  lo_reg   <= 32'hFFFF_FFFF;
`endif
               end
            end
            ST_MULT: begin
               if (count_reg == 5'd0) begin
                  done_reg <= 1'b1;
                  wr_reg   <= 1'b1;
                  hi_reg   <= step_acc[64:33];
                  lo_reg   <= step_acc[32:1];
               end
            end
            ST_DSIGN: begin
               done_reg <= 1'b1;
               wr_reg   <= 1'b1;
               lo_reg   <= q_neg_reg ? (~quo_reg + 32'd1) : quo_reg;
               hi_reg   <= r_neg_reg ? (~rem_reg + 32'd1) : rem_reg;
            end
            default: ;
         endcase
      end
   end

   assign busy     = (state_reg != ST_IDLE);
   assign done     = done_reg;
   assign write_hi = wr_reg;
   assign write_lo = wr_reg;
   assign hi_out   = hi_reg;
   assign lo_out   = lo_reg;
`ifdef MULDIV_DIVZERO_EXC_EN
   assign div_zero = divz_reg;
`endif

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: self-checking bench for muldiv_seq. Expected results come
// from plain 64-bit signed arithmetic on the operands.
// Honors MULDIV_DIVZERO_EXC_EN the same way the design does.
module tb_muldiv_seq;

   logic        clock;
   logic        reset;
   logic        start_mult;
   logic        start_div;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        busy;
   logic        done;
   logic        write_hi;
   logic        write_lo;
   logic [31:0] hi_out;
   logic [31:0] lo_out;
`ifdef MULDIV_DIVZERO_EXC_EN
   logic        div_zero;
`endif

   int n_total = 0;
   int n_pass  = 0;

   logic [31:0] last_hi = 32'd0;
   logic [31:0] last_lo = 32'd0;

   muldiv_seq dut (
      .clock      (clock),
      .reset      (reset),
      .start_mult (start_mult),
      .start_div  (start_div),
      .op_a       (op_a),
      .op_b       (op_b),
      .busy       (busy),
      .done       (done),
      .write_hi   (write_hi),
      .write_lo   (write_lo),
      .hi_out     (hi_out),
      .lo_out     (lo_out)
`ifdef MULDIV_DIVZERO_EXC_EN
      ,
      .div_zero   (div_zero)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [31:0] pick_operand();
      int unsigned r;
      r = $urandom_range(0, 9);
      case (r)
         0: return 32'h0000_0000;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'h0000_0001;
         4: return 32'(($urandom_range(0, 40)) - 20);
         default: return $urandom;
      endcase
   endfunction

   // Issue one operation, follow it to completion and compare with the model
   task automatic do_op(input bit is_mult, input logic [31:0] a, input logic [31:0] b, input string tag);
      longint     sa, sb, p, q, r;
      logic [63:0] exp_res;
      int         exp_lat;
      bit         exp_wr;
      bit         exp_dz;
      int         lat;
      bit         busy_ok;

      sa = longint'($signed(a));
      sb = longint'($signed(b));
      exp_wr = 1'b1;
      exp_dz = 1'b0;
      if (is_mult) begin
         p       = sa * sb;
         exp_res = p;
         exp_lat = 33;
      end else if (b == 32'd0) begin
         exp_lat = 1;
`ifdef MULDIV_DIVZERO_EXC_EN
         exp_res = {last_hi, last_lo};
         exp_wr  = 1'b0;
         exp_dz  = 1'b1;
`else
         exp_res = {a, 32'hFFFF_FFFF};
`endif
      end else begin
         q       = sa / sb;
         r       = sa % sb;
         exp_res = {r[31:0], q[31:0]};
         exp_lat = 34;
      end

      @(negedge clock);
      start_mult = is_mult;
      start_div  = !is_mult;
      op_a       = a;
      op_b       = b;
      @(posedge clock);
      #1;
      start_mult = 1'b0;
      start_div  = 1'b0;
      op_a       = $urandom;
      op_b       = $urandom;

      lat     = 0;
      busy_ok = 1'b1;
      for (int n = 1; n <= 45; n++) begin
         @(negedge clock);
         if (!busy) busy_ok = 1'b0;
         if (done) begin
            lat = n;
            break;
         end
      end
      check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check({tag, " busy"}, 64'(busy_ok), 64'd1);
      check({tag, " result"}, {hi_out, lo_out}, exp_res);
      check({tag, " strobes"}, {62'd0, write_hi, write_lo}, {62'd0, exp_wr, exp_wr});
`ifdef MULDIV_DIVZERO_EXC_EN
      check({tag, " div_zero"}, 64'(div_zero), 64'(exp_dz));
`endif
      $display("op %s %s a=%h b=%h hi=%h lo=%h cycles=%0d", tag, is_mult ? "MULT" : "DIV",
               a, b, hi_out, lo_out, lat);
      if (exp_wr) begin
         last_hi = exp_res[63:32];
         last_lo = exp_res[31:0];
      end
      @(negedge clock);
      check({tag, " idle after"}, {62'd0, busy, done}, 64'd0);
   endtask

   initial begin
      logic [63:0] p_exp;
      logic [31:0] ra, rb;
      int          n_done;
      int          lat;
      logic [63:0] got_res;

      reset      = 1'b1;
      start_mult = 1'b0;
      start_div  = 1'b0;
      op_a       = 32'd0;
      op_b       = 32'd0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("reset outputs", {hi_out, lo_out}, 64'd0);
      check("reset flags", {60'd0, busy, done, write_hi, write_lo}, 64'd0);
      reset = 1'b0;

      // Directed cases
      do_op(1'b1, 32'h0000_0007, 32'hFFFF_FFFD, "mult_7x-3");
      do_op(1'b1, 32'h8000_0000, 32'h8000_0000, "mult_min_sq");
      do_op(1'b0, 32'hFFFF_FFF9, 32'h0000_0002, "div_-7/2");
      do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
      do_op(1'b0, 32'h0000_0005, 32'h0000_0000, "div_5/0");

      // Simultaneous starts, then a stray start_div in cycle 5
      p_exp = longint'($signed(32'h0001_2345)) * longint'($signed(32'hFFFF_FFF7));
      @(negedge clock);
      start_mult = 1'b1;
      start_div  = 1'b1;
      op_a       = 32'h0001_2345;
      op_b       = 32'hFFFF_FFF7;
      @(posedge clock);
      #1;
      start_mult = 1'b0;
      start_div  = 1'b0;
      op_b       = 32'd0;
      n_done  = 0;
      lat     = 0;
      got_res = '0;
      for (int n = 1; n <= 45; n++) begin
         @(negedge clock);
         if (n == 4) start_div = 1'b1;
         if (n == 5) start_div = 1'b0;
         if (done) begin
            n_done++;
            if (lat == 0) begin
               lat     = n;
               got_res = {hi_out, lo_out};
            end
         end
      end
      check("dual done count", 64'(n_done), 64'd1);
      check("dual latency", 64'(lat), 64'd33);
      check("dual result", got_res, p_exp);
      $display("op dual_start MULT hi=%h lo=%h cycles=%0d dones=%0d", got_res[63:32], got_res[31:0], lat, n_done);
      last_hi = p_exp[63:32];
      last_lo = p_exp[31:0];

      // Reset during a divide
      @(negedge clock);
      start_div = 1'b1;
      op_a      = 32'd100;
      op_b      = 32'd7;
      @(posedge clock);
      #1;
      start_div = 1'b0;
      for (int n = 1; n <= 9; n++) @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      check("midrst outputs", {hi_out, lo_out}, 64'd0);
      check("midrst flags", {60'd0, busy, done, write_hi, write_lo}, 64'd0);
      n_done = 0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clock);
         if (done || write_hi || write_lo) n_done++;
      end
      check("midrst no done", 64'(n_done), 64'd0);
      $display("op midrst DIV aborted by reset, strobes seen=%0d", n_done);
      last_hi = 32'd0;
      last_lo = 32'd0;
      do_op(1'b1, 32'd2, 32'd3, "mult_2x3");

      // Randomized mix
      for (int i = 0; i < 24; i++) begin
         ra = pick_operand();
         rb = pick_operand();
         do_op(($urandom_range(0, 1) == 1), ra, rb, $sformatf("rnd%0d", i));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
